// File: rtl/control_unit.sv
// Fetch/exec sequencer for the accumulator CPU: takes at least 2 cycles per instruction, 1 FETCH plus 1 EXEC.
// Stalls in FETCH with the request and address held while imem_valid is low; HALT is terminal until reset.
module control_unit #(
  parameter int UNDEFINED     = 3,
  parameter int CNTR_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 5,
  parameter int REG_BIT_CNT   = 3,
  parameter int DATA_WIDTH    = 8,
  parameter int COMBINED_DATA = ADDR_WIDTH + UNDEFINED + DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req,
  output logic [CNTR_WIDTH-1:0]    imem_addr,
  input  logic [COMBINED_DATA-1:0] imem_data,
  input  logic                     imem_valid,
  output logic [ADDR_WIDTH-1:0]    alu_operation,
  output logic [DATA_WIDTH-1:0]    alu_in1,
  output logic [DATA_WIDTH-1:0]    alu_in2,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  input  logic                     alu_zero_f,
  input  logic                     alu_ls_z_f,
  input  logic                     alu_gr_z_f,
  output logic [DATA_WIDTH-1:0]    acc_out,
  output logic                     halted
);

  localparam int NUM_REGS = 1 << REG_BIT_CNT;

  // Opcodes 0..16 are the alu's own; the control-flow/store ops sit just above them.
  localparam logic [ADDR_WIDTH-1:0] OP_NOP  = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] OP_XOR  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] OP_OR   = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] OP_AND  = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] OP_SUBR = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] OP_ADDR = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] OP_SR   = ADDR_WIDTH'(6);
  localparam logic [ADDR_WIDTH-1:0] OP_SL   = ADDR_WIDTH'(7);
  localparam logic [ADDR_WIDTH-1:0] OP_RR   = ADDR_WIDTH'(8);
  localparam logic [ADDR_WIDTH-1:0] OP_RL   = ADDR_WIDTH'(9);
  localparam logic [ADDR_WIDTH-1:0] OP_DEC  = ADDR_WIDTH'(10);
  localparam logic [ADDR_WIDTH-1:0] OP_INC  = ADDR_WIDTH'(11);
  localparam logic [ADDR_WIDTH-1:0] OP_NOT  = ADDR_WIDTH'(12);
  localparam logic [ADDR_WIDTH-1:0] OP_SUBI = ADDR_WIDTH'(13);
  localparam logic [ADDR_WIDTH-1:0] OP_ADDI = ADDR_WIDTH'(14);
  localparam logic [ADDR_WIDTH-1:0] OP_LDI  = ADDR_WIDTH'(15);
  localparam logic [ADDR_WIDTH-1:0] OP_LDR  = ADDR_WIDTH'(16);
  localparam logic [ADDR_WIDTH-1:0] OP_JMP  = ADDR_WIDTH'(17);
  localparam logic [ADDR_WIDTH-1:0] OP_JZ   = ADDR_WIDTH'(18);
  localparam logic [ADDR_WIDTH-1:0] OP_JN   = ADDR_WIDTH'(19);
  localparam logic [ADDR_WIDTH-1:0] OP_JP   = ADDR_WIDTH'(20);
  localparam logic [ADDR_WIDTH-1:0] OP_STR  = ADDR_WIDTH'(21);
  localparam logic [ADDR_WIDTH-1:0] OP_HLT  = ADDR_WIDTH'(22);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [CNTR_WIDTH-1:0]      r_pc;
  logic [CNTR_WIDTH-1:0]      w_pc_nxt;
  logic [DATA_WIDTH-1:0]      r_acc;
  logic [COMBINED_DATA-1:0]   r_ir;
  logic [DATA_WIDTH-1:0]      r_regs [NUM_REGS];
  logic                       r_z;
  logic                       r_n;
  logic                       r_p;

  logic [ADDR_WIDTH-1:0]      w_opcode;
  logic [DATA_WIDTH-1:0]      w_operand;
  logic [REG_BIT_CNT-1:0]     w_ridx;
  logic [CNTR_WIDTH-1:0]      w_target;
  logic [CNTR_WIDTH-1:0]      w_pc_inc;
  logic                       w_unused_pad;
  logic                       w_is_alu;
  logic                       w_uses_reg;
  logic                       w_in_exec;
  logic                       w_ir_load;
  logic                       w_acc_we;
  logic                       w_flag_we;
  logic                       w_reg_we;

  assign w_opcode     = r_ir[COMBINED_DATA-1 -: ADDR_WIDTH];
  assign w_operand    = r_ir[DATA_WIDTH-1:0];
  assign w_ridx       = w_operand[REG_BIT_CNT-1:0];
  assign w_target     = w_operand[CNTR_WIDTH-1:0];
  assign w_pc_inc     = r_pc + CNTR_WIDTH'(1);
  assign w_unused_pad = ^r_ir[DATA_WIDTH +: UNDEFINED];
  assign w_in_exec    = (r_state == S_EXEC);

  // NOP and unknown opcodes fall out as non-ALU, so they leave ACC and flags alone.
  always_comb begin
    w_is_alu   = 1'b0;
    w_uses_reg = 1'b0;
    case (w_opcode)
      OP_XOR, OP_OR, OP_AND, OP_SUBR, OP_ADDR, OP_LDR: begin
        w_is_alu   = 1'b1;
        w_uses_reg = 1'b1;
      end
      OP_SR, OP_SL, OP_RR, OP_RL, OP_DEC, OP_INC, OP_NOT,
      OP_SUBI, OP_ADDI, OP_LDI: begin
        w_is_alu = 1'b1;
      end
      default: begin
        w_is_alu   = 1'b0;
        w_uses_reg = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_ir_load   = 1'b0;
    w_acc_we    = 1'b0;
    w_flag_we   = 1'b0;
    w_reg_we    = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (imem_valid) begin
          w_ir_load   = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_state_nxt = S_FETCH;
        w_pc_nxt    = w_pc_inc;
        case (w_opcode)
          OP_JMP: w_pc_nxt = w_target;
          OP_JZ:  if (r_z) w_pc_nxt = w_target;
          OP_JN:  if (r_n) w_pc_nxt = w_target;
          OP_JP:  if (r_p) w_pc_nxt = w_target;
          OP_STR: w_reg_we = 1'b1;
          OP_HLT: begin
            w_state_nxt = S_HALT;
            w_pc_nxt    = r_pc;
          end
          default: begin
            w_acc_we  = w_is_alu;
            w_flag_we = w_is_alu;
          end
        endcase
      end
      default: begin
        w_state_nxt = S_HALT;
      end
    endcase
  end

  always_comb begin
    imem_req      = (r_state == S_FETCH);
    imem_addr     = r_pc;
    halted        = (r_state == S_HALT);
    alu_in1       = r_acc;
    acc_out       = r_acc;
    alu_operation = OP_NOP;
    alu_in2       = '0;
    if (w_in_exec && w_is_alu) begin
      alu_operation = w_opcode;
      alu_in2       = w_uses_reg ? r_regs[w_ridx] : w_operand;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc  <= '0;
      r_acc <= '0;
      r_ir  <= '0;
      r_z   <= 1'b0;
      r_n   <= 1'b0;
      r_p   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_pc <= w_pc_nxt;
      if (w_ir_load) begin
        r_ir <= imem_data;
      end
      if (w_acc_we) begin
        r_acc <= alu_result;
      end
      if (w_flag_we) begin
        r_z <= alu_zero_f;
        r_n <= alu_ls_z_f;
        r_p <= alu_gr_z_f;
      end
      if (w_reg_we) begin
        r_regs[w_ridx] <= r_acc;
      end
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with a behavioural alu model; checks via immediate assertions.
module tb_control_unit;

  localparam logic [4:0] NOP  = 5'd0,  ADDR = 5'd5,  DEC  = 5'd10, INC = 5'd11;
  localparam logic [4:0] ADDI = 5'd14, LDI  = 5'd15, LDR  = 5'd16, JMP = 5'd17;
  localparam logic [4:0] JZ   = 5'd18, JN   = 5'd19, JP   = 5'd20, STR = 5'd21;
  localparam logic [4:0] HLT  = 5'd22;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic [4:0]  alu_operation;
  logic [7:0]  alu_in1;
  logic [7:0]  alu_in2;
  logic [7:0]  alu_result;
  logic        alu_zero_f;
  logic        alu_ls_z_f;
  logic        alu_gr_z_f;
  logic [7:0]  acc_out;
  logic        halted;

  int vecs;
  int errs;

  control_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .imem_valid    (imem_valid),
    .alu_operation (alu_operation),
    .alu_in1       (alu_in1),
    .alu_in2       (alu_in2),
    .alu_result    (alu_result),
    .alu_zero_f    (alu_zero_f),
    .alu_ls_z_f    (alu_ls_z_f),
    .alu_gr_z_f    (alu_gr_z_f),
    .acc_out       (acc_out),
    .halted        (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Combinational alu stand-in; flags treat the result as signed.
  always_comb begin
    alu_result = alu_in1;
    case (alu_operation)
      5'd1:      alu_result = alu_in1 ^ alu_in2;
      5'd2:      alu_result = alu_in1 | alu_in2;
      5'd3:      alu_result = alu_in1 & alu_in2;
      5'd4, 5'd13: alu_result = alu_in1 - alu_in2;
      5'd5, 5'd14: alu_result = alu_in1 + alu_in2;
      5'd6:      alu_result = alu_in1 >> 1;
      5'd7:      alu_result = alu_in1 << 1;
      5'd8:      alu_result = {alu_in1[0], alu_in1[7:1]};
      5'd9:      alu_result = {alu_in1[6:0], alu_in1[7]};
      5'd10:     alu_result = alu_in1 - 8'd1;
      5'd11:     alu_result = alu_in1 + 8'd1;
      5'd12:     alu_result = ~alu_in1;
      5'd15, 5'd16: alu_result = alu_in2;
      default:   alu_result = alu_in1;
    endcase
  end
  assign alu_zero_f = (alu_result == 8'h00);
  assign alu_ls_z_f = alu_result[7];
  assign alu_gr_z_f = (alu_result != 8'h00) && !alu_result[7];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Leaves the DUT in its EXEC cycle for the given instruction.
  task automatic fetch_op(input logic [4:0] op, input logic [7:0] opnd);
    chk("fetch_req", imem_req, 1);
    imem_data  = {op, 3'b000, opnd};
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    chk("exec_req", imem_req, 0);
  endtask

  task automatic step(input logic [4:0] op, input logic [7:0] opnd);
    fetch_op(op, opnd);
    tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},  imem_req, 1);
    chk({tag, "_addr"}, imem_addr, 8'h00);
    chk({tag, "_op"},   alu_operation, NOP);
    chk({tag, "_in1"},  alu_in1, 8'h00);
    chk({tag, "_in2"},  alu_in2, 8'h00);
    chk({tag, "_acc"},  acc_out, 8'h00);
    chk({tag, "_halt"}, halted, 0);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    vecs       = 0;
    errs       = 0;
    rst_n      = 1'b0;
    imem_valid = 1'b0;
    imem_data  = '0;
    @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;

    // Reset asserted during the EXEC of ADDi 0x10
    fetch_op(ADDI, 8'h10);
    chk("midexec_op",  alu_operation, ADDI);
    chk("midexec_in2", alu_in2, 8'h10);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midexec_rst");
    tick();
    rst_n = 1'b1;
    chk("midexec_rel_req",  imem_req, 1);
    chk("midexec_rel_addr", imem_addr, 8'h00);
    chk("midexec_rel_acc",  acc_out, 8'h00);

    // Arithmetic and register file
    step(LDI, 8'h05);
    step(ADDI, 8'h03);
    chk("addi_acc", acc_out, 8'h08);
    step(STR, 8'h02);
    step(LDI, 8'h00);
    chk("ldi0_acc", acc_out, 8'h00);
    fetch_op(ADDR, 8'h02);
    chk("addr_in2", alu_in2, 8'h08);
    tick();
    chk("addr_acc", acc_out, 8'h08);
    chk("addr_pc",  imem_addr, 8'h05);
    step(JZ, 8'h50);
    chk("jz_nt_pc", imem_addr, 8'h06);
    step(JN, 8'h50);
    chk("jn_nt_pc", imem_addr, 8'h07);
    step(JP, 8'h40);
    chk("jp_t_pc",  imem_addr, 8'h40);

    // Conditional jumps
    do_reset("rst_a");
    step(LDI, 8'h01);
    step(DEC, 8'h00);
    chk("dec_acc0", acc_out, 8'h00);
    step(JZ, 8'h10);
    chk("jz_taken", imem_addr, 8'h10);
    do_reset("rst_b");
    step(LDI, 8'h02);
    step(DEC, 8'h00);
    chk("dec_acc1", acc_out, 8'h01);
    step(JZ, 8'h10);
    chk("jz_not_taken", imem_addr, 8'h03);

    // PC wrap and sign flag
    step(LDI, 8'h7F);
    step(JMP, 8'hFF);
    chk("jmp_ff", imem_addr, 8'hFF);
    step(INC, 8'h00);
    chk("inc_acc",  acc_out, 8'h80);
    chk("inc_wrap", imem_addr, 8'h00);
    step(JN, 8'h20);
    chk("jn_taken", imem_addr, 8'h20);
    step(JP, 8'h20);
    chk("jp_not_taken", imem_addr, 8'h21);

    // Fetch stall
    imem_data  = {ADDI, 3'b000, 8'h01};
    imem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_req",  imem_req, 1);
      chk("stall_addr", imem_addr, 8'h21);
      chk("stall_acc",  acc_out, 8'h80);
    end
    imem_valid = 1'b1;
    tick();
    imem_valid = 1'b0;
    chk("stall_exec_op", alu_operation, ADDI);
    tick();
    chk("stall_done_acc",  acc_out, 8'h81);
    chk("stall_done_addr", imem_addr, 8'h22);
    tick();
    chk("stall_once_acc",  acc_out, 8'h81);
    chk("stall_once_addr", imem_addr, 8'h22);
    chk("stall_once_req",  imem_req, 1);

    // Halt at PC=0x07
    step(JMP, 8'h07);
    chk("jmp_07", imem_addr, 8'h07);
    fetch_op(HLT, 8'h00);
    chk("hlt_exec_halted", halted, 0);
    tick();
    chk("halted_rise", halted, 1);
    chk("halted_req",  imem_req, 0);
    for (int i = 0; i < 12; i++) begin
      imem_valid = i[0];
      imem_data  = {LDI, 3'b000, 8'hAA};
      tick();
      chk("halt_hold",      halted, 1);
      chk("halt_req",       imem_req, 0);
      chk("halt_acc",       acc_out, 8'h81);
      chk("halt_addr",      imem_addr, 8'h07);
    end
    imem_valid = 1'b0;
    do_reset("rst_halt");
    chk("restart_halted", halted, 0);
    chk("restart_addr",   imem_addr, 8'h00);
    step(LDI, 8'h33);
    chk("restart_acc",    acc_out, 8'h33);
    chk("restart_pc",     imem_addr, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Sequencer for the wannabe-CPU datapath: fetches instruction words from instruction memory, decodes them, and drives the `alu` block's `operation`/`in1_acc`/`in2_reg` inputs. It consumes `data_out` and the three flags. It owns the program counter, accumulator, register file and flag register, and resolves conditional jumps from the latched flags. It sits between instruction memory and `alu` at the top of the CPU.

## Interface
Parameters:
- `UNDEFINED`, 3, unused padding bits between opcode and operand in the instruction word
- `CNTR_WIDTH`, 8, program counter / instruction address width
- `ADDR_WIDTH`, 5, opcode width; equals the `alu` `operation` width
- `REG_BIT_CNT`, 3, register index width; the register file holds 2^REG_BIT_CNT entries
- `DATA_WIDTH`, 8, datapath width
- `COMBINED_DATA`, ADDR_WIDTH+UNDEFINED+DATA_WIDTH, instruction word width

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  fetch request
- `imem_addr`  out  CNTR_WIDTH  fetch address, equal to the PC
- `imem_data`  in  COMBINED_DATA  instruction word, laid out as {opcode[ADDR_WIDTH], pad[UNDEFINED], operand[DATA_WIDTH]}
- `imem_valid`  in  1  `imem_data` is valid for the current request
- `alu_operation`  out  ADDR_WIDTH  connects to `alu.operation`
- `alu_in1`  out  DATA_WIDTH  the accumulator; connects to `alu.in1_acc`
- `alu_in2`  out  DATA_WIDTH  the second operand; connects to `alu.in2_reg`
- `alu_result`  in  DATA_WIDTH  from `alu.data_out`
- `alu_zero_f`, `alu_ls_z_f`, `alu_gr_z_f`  in  1 each  flags from `alu`
- `acc_out`  out  DATA_WIDTH  accumulator, for debug
- `halted`  out  1  the core has executed HLT

## Operation
- Opcodes come from `src/instructions.v`. This block adds `JMP`, `JZ`, `JN`, `JP`, `STr` and `HLT` to that file, using encodings that do not collide with the existing ones.
- The FSM has three states: FETCH, EXEC and HALT. Reset enters FETCH.
- **FETCH**
  - `imem_req`=1 and `imem_addr`=PC.
  - On the first edge where `imem_valid`=1, the instruction register (IR) captures `imem_data` and the state moves to EXEC.
  - Otherwise the FSM stays in FETCH, with `imem_req` and `imem_addr` held stable.
- **EXEC** (exactly one cycle, `imem_req`=0):
  - ALU-class ops (`NOP`, `XOR`, `OR`, `AND`, `SUBr`, `ADDr`, `SR`, `SL`, `RR`, `RL`, `DEC`, `INC`, `NOT`, `SUBi`, `ADDi`, `LDi`, `LDr`):
    - `alu_operation` = IR opcode.
    - `alu_in2` = operand for `*i` ops, or reg[operand[REG_BIT_CNT-1:0]] for `*r` ops.
    - At the edge, ACC <= `alu_result` and {Z,N,P} <= {`alu_zero_f`, `alu_ls_z_f`, `alu_gr_z_f`}. Exception: `NOP` updates neither ACC nor flags.
  - `STr`: reg[operand[REG_BIT_CNT-1:0]] <= ACC. Flags are unchanged.
  - `JMP`: PC <= operand[CNTR_WIDTH-1:0].
  - `JZ`, `JN`, `JP`: jump when the latched Z, N or P flag respectively is 1; otherwise PC <= PC+1. The flags tested are the values latched by the most recent flag-updating instruction.
  - `HLT`: the state moves to HALT. PC is not incremented.
  - Unrecognised opcode: behaves as `NOP`.
  - Every non-jump, non-HLT op sets PC <= PC+1, modulo 2^CNTR_WIDTH (0xFF wraps to 0x00).
  - After EXEC the state returns to FETCH, except for HLT.
- **Outside EXEC**: `alu_operation` = `NOP` encoding and `alu_in2` = 0. `alu_in1` is always ACC.
- **HALT**: terminal. `imem_req`=0, `halted`=1, no state changes. Only `rst_n` exits it.
- **Reset values**: PC=0, ACC=0, all registers 0, Z=N=P=0, IR=0 and state FETCH. Outputs are therefore `imem_req`=1, `imem_addr`=0, `alu_operation`=`NOP`, `alu_in1`=0, `alu_in2`=0, `acc_out`=0, `halted`=0.
- **Reset mid-operation**: any in-flight fetch or exec is abandoned immediately (asynchronously). No register update from that instruction occurs.
- **`imem_valid` while `imem_req`=0**: ignored.

## Timing
- Minimum 2 cycles per instruction: 1 FETCH cycle when `imem_valid` is already high, plus 1 EXEC cycle. Each cycle `imem_valid` stays low adds 1 cycle.
- `imem_data` is sampled only on an edge where `imem_req`&&`imem_valid`.
- The ALU is combinational. Its result and flags are sampled on the EXEC edge, so ACC and the flags are visible in the next FETCH cycle.
- `halted` rises on the edge that ends the HLT EXEC cycle.
- Register-before-use is handled by construction: `STr` followed by `LDr`/`ADDr` on the same register sees the new value, because the write completes before the next EXEC.

## Test plan
- **Reset mid-EXEC**: assert `rst_n`=0 during the EXEC of `ADDi` 0x10. Required: ACC stays 0x00 and all outputs take their reset values. On release, `imem_req`=1 with `imem_addr`=0x00.
- **Arithmetic and register file**: run `LDi` 0x05, `ADDi` 0x03, `STr` r2, `LDi` 0x00, `ADDr` r2. Required: final ACC=0x08, reg2=0x08, PC=0x05, flags Z=0 N=0 P=1.
- **Conditional jumps**: run `LDi` 0x01, `DEC`, `JZ` 0x10. Required: next `imem_addr`=0x10. Repeat with `LDi` 0x02. Required: `imem_addr`=0x03 (not taken).
- **Wrap and sign flags**:
  - Execute `INC` at PC=0xFF with ACC=0x7F. Required: ACC=0x80, N=1, next `imem_addr`=0x00.
  - Then `JN` 0x20 is taken and `JP` 0x20 is not taken.
- **Fetch stall**: hold `imem_valid`=0 for 3 cycles. Required: `imem_req` and `imem_addr` stable and ACC unchanged. Raise `imem_valid` for one cycle. Required: EXEC occurs exactly once.
- **Halt**: execute `HLT` at PC=0x07. Required: `halted`=1 and `imem_req`=0 for 10 or more cycles with `imem_valid` toggling. After reset, `halted`=0 and fetch restarts at 0x00.
